// File: rtl/edge_pkg.sv
// Shared types and defaults for the edge-detection pipeline sequencer.
package edge_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int V_ACTIVE_DEF = 480;
  localparam int NUM_LB       = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BLANK  = 2'd1,
    ST_ACTIVE = 2'd2
  } state_t;

  function automatic logic [1:0] next_sel(input logic [1:0] sel);
    return (sel == 2'(NUM_LB - 1)) ? 2'd0 : sel + 2'd1;
  endfunction

endpackage

// File: rtl/edge_pipeline_ctrl_sync_delay_line.sv
// Fixed-depth shift register that re-times a small bundle of sync bits.
module sync_delay_line #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 4
) (
  input  logic             O_PCLK,
  input  logic             I_RST,
  input  logic [WIDTH-1:0] sync_in,
  output logic [WIDTH-1:0] sync_out
);

  logic [WIDTH-1:0] sr [DEPTH];

  always_ff @(posedge O_PCLK) begin
    if (I_RST) begin
      for (int i = 0; i < DEPTH; i++) sr[i] <= '0;
    end else begin
      sr[0] <= sync_in;
      for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
    end
  end

  assign sync_out = sr[DEPTH-1];

endmodule

// File: rtl/edge_pipeline_ctrl.sv
// Frame/line/pixel sequencer: drives the 3-line rotating buffer writes,
// flags complete 3x3 windows and re-times sync to the datapath latency.
module edge_pipeline_ctrl
  import edge_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int ADDR_W   = 10,
  parameter int ROW_W    = 9,
  parameter int PIPE_LAT = 4
) (
  input  logic              O_PCLK,
  input  logic              I_RST,
  input  logic              I_VSYNC,
  input  logic              I_HSYNC,
  input  logic              I_DE,
  output logic              O_LB_WR_EN,
  output logic [ADDR_W-1:0] O_LB_ADDR,
  output logic [1:0]        O_LB_SEL,
  output logic              O_WIN_VALID,
  output logic [ROW_W-1:0]  O_ROW,
  output logic              O_VSYNC_D,
  output logic              O_HSYNC_D,
  output logic              O_DE_D,
  output logic              O_FRAME_ERR
);

  // One spare bit so col/row can sit at H_ACTIVE/V_ACTIVE when those equal 2**W.
  localparam int COL_W = ADDR_W + 1;
  localparam int RW    = ROW_W + 1;
  localparam logic [COL_W-1:0] H_MAX = COL_W'(H_ACTIVE);
  localparam logic [RW-1:0]    V_MAX = RW'(V_ACTIVE);

  state_t           state, state_n;
  logic [COL_W-1:0] col, col_n;
  logic [RW-1:0]    row, row_n;
  logic [1:0]       sel, sel_n;
  logic             ovf, ovf_n;
  logic             vsync_prev, vs_rise;
  logic             wr, err, win;
  logic [2:0]       sync_d;

  assign vs_rise = I_VSYNC & ~vsync_prev;

  always_comb begin
    state_n = state;
    col_n   = col;
    row_n   = row;
    sel_n   = sel;
    ovf_n   = ovf;
    wr      = 1'b0;
    err     = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (vs_rise) begin
          state_n = ST_BLANK;
          col_n   = '0;
          row_n   = '0;
          sel_n   = '0;
          ovf_n   = 1'b0;
        end
      end
      ST_BLANK: begin
        if (vs_rise) begin
          col_n = '0;
          row_n = '0;
          sel_n = '0;
          ovf_n = 1'b0;
        end else if (I_DE) begin
          if (row < V_MAX) begin
            state_n = ST_ACTIVE;
            wr      = 1'b1;
            col_n   = COL_W'(1);
          end else begin
            err = 1'b1;
          end
        end
      end
      ST_ACTIVE: begin
        if (vs_rise) begin
          err     = 1'b1;
          state_n = ST_BLANK;
          col_n   = '0;
          row_n   = '0;
          sel_n   = '0;
          ovf_n   = 1'b0;
        end else if (I_DE) begin
          if (col < H_MAX) begin
            wr    = 1'b1;
            col_n = col + 1'b1;
          end else if (!ovf) begin
            // overlong line: flag once, then ignore the rest of it
            err   = 1'b1;
            ovf_n = 1'b1;
          end
        end else begin
          state_n = ST_BLANK;
          err     = (col != H_MAX);
          col_n   = '0;
          ovf_n   = 1'b0;
          sel_n   = next_sel(sel);
          if (row < V_MAX) row_n = row + 1'b1;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  assign win = wr && (row >= RW'(2)) && (col >= COL_W'(2));

  always_ff @(posedge O_PCLK) begin
    if (I_RST) begin
      state       <= ST_IDLE;
      col         <= '0;
      row         <= '0;
      sel         <= '0;
      ovf         <= 1'b0;
      vsync_prev  <= 1'b1;
      O_LB_WR_EN  <= 1'b0;
      O_LB_ADDR   <= '0;
      O_LB_SEL    <= '0;
      O_WIN_VALID <= 1'b0;
      O_ROW       <= '0;
      O_FRAME_ERR <= 1'b0;
    end else begin
      state       <= state_n;
      col         <= col_n;
      row         <= row_n;
      sel         <= sel_n;
      ovf         <= ovf_n;
      vsync_prev  <= I_VSYNC;
      O_LB_WR_EN  <= wr;
      O_LB_ADDR   <= col[ADDR_W-1:0];
      O_LB_SEL    <= sel;
      O_WIN_VALID <= win;
      O_ROW       <= row[ROW_W-1:0];
      O_FRAME_ERR <= err;
    end
  end

  sync_delay_line #(
    .WIDTH(3),
    .DEPTH(PIPE_LAT)
  ) u_sync_dly (
    .O_PCLK  (O_PCLK),
    .I_RST   (I_RST),
    .sync_in ({I_VSYNC, I_HSYNC, I_DE}),
    .sync_out(sync_d)
  );

  assign {O_VSYNC_D, O_HSYNC_D, O_DE_D} = sync_d;

endmodule
